// File: rtl/boot_loader.sv
// boot_loader: byte-stream program loader.
// Receives a length-prefixed, XOR-checksummed instruction image, writes each
// 32-bit instruction as a zero-extended 64-bit RAM word starting at BASE_ADDR,
// and keeps the CPU in reset until the image has loaded and its checksum
// matches.
module boot_loader #(
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'('h800),
  parameter int                MAX_WORDS = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] words_loaded
);

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_INSTR,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  // Largest legal instruction count, widened so a 16-bit count compares cleanly.
  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  state_t      state;
  state_t      state_next;

  logic        xfer;        // a byte is accepted on this edge
  logic [7:0]  len_lo;      // low length byte, held until the high byte arrives
  logic [15:0] len;         // instruction count N of the current image
  logic [15:0] len_rx;      // count formed from the incoming high byte
  logic [31:0] instr;       // instruction assembly register (bytes shift in from the top)
  logic [1:0]  byte_idx;    // which byte of the current instruction is next
  logic [7:0]  xsum;        // running XOR of every non-checksum byte
  logic        last_word;   // the instruction being written is the N-th
  logic        reload_hit;  // reload taken from a terminal state

  logic        done_next;
  logic        error_next;
  logic        cpu_rst_next;

  // Byte acceptance is a pure function of state, and always refused during reset.
  assign rx_ready = !rst && (state inside {S_LEN_LO, S_LEN_HI, S_INSTR, S_CSUM});
  assign xfer     = rx_valid && rx_ready;

  assign len_rx     = {rx_data, len_lo};
  assign last_word  = (16'(words_loaded) + 16'd1) == len;
  assign reload_hit = reload && (state inside {S_DONE, S_ERROR});

  // Write port: address tracks the running count; data only shown while writing.
  assign mem_addr  = BASE_ADDR + words_loaded;
  assign mem_wdata = mem_we ? {32'b0, instr} : 64'b0;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_LEN_LO;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus write strobe and next values of the status flags.
  always_comb begin
    state_next   = state;
    mem_we       = 1'b0;
    done_next    = 1'b0;
    error_next   = 1'b0;
    cpu_rst_next = 1'b1;
    case (state)
      S_LEN_LO: begin
        if (xfer) begin
          state_next = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          if ({1'b0, len_rx} > MAX_N) begin
            state_next = S_ERROR;
          end else if (len_rx == 16'd0) begin
            state_next = S_CSUM;
          end else begin
            state_next = S_INSTR;
          end
        end
      end
      S_INSTR: begin
        if (xfer && (byte_idx == 2'd3)) begin
          state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        mem_we = 1'b1;
        if (last_word) begin
          state_next = S_CSUM;
        end else begin
          state_next = S_INSTR;
        end
      end
      S_CSUM: begin
        if (xfer) begin
          if (rx_data == xsum) begin
            state_next = S_DONE;
          end else begin
            state_next = S_ERROR;
          end
        end
      end
      S_DONE: begin
        if (reload) begin
          state_next = S_LEN_LO;
        end else begin
          done_next    = 1'b1;
          cpu_rst_next = 1'b0;
        end
      end
      S_ERROR: begin
        if (reload) begin
          state_next = S_LEN_LO;
        end else begin
          error_next = 1'b1;
        end
      end
      default: begin
        state_next = S_LEN_LO;
      end
    endcase
  end

  // Status flags lag the terminal state by one cycle and drop on reload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done    <= 1'b0;
      error   <= 1'b0;
      cpu_rst <= 1'b1;
    end else begin
      done    <= done_next;
      error   <= error_next;
      cpu_rst <= cpu_rst_next;
    end
  end

  // Length capture: low byte is parked, full count formed with the high byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_lo <= 8'd0;
      len    <= 16'd0;
    end else if (xfer) begin
      if (state == S_LEN_LO) begin
        len_lo <= rx_data;
      end
      if (state == S_LEN_HI) begin
        len <= len_rx;
      end
    end
  end

  // Instruction assembly: little-endian, so each new byte enters at the top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr    <= 32'd0;
      byte_idx <= 2'd0;
    end else if (reload_hit) begin
      byte_idx <= 2'd0;
    end else if (xfer && (state == S_LEN_HI)) begin
      byte_idx <= 2'd0;
    end else if (xfer && (state == S_INSTR)) begin
      instr    <= {rx_data, instr[31:8]};
      byte_idx <= byte_idx + 2'd1;
    end
  end

  // Running XOR over length and instruction bytes; the checksum byte is excluded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xsum <= 8'd0;
    end else if (reload_hit) begin
      xsum <= 8'd0;
    end else if (xfer && (state != S_CSUM)) begin
      xsum <= xsum ^ rx_data;
    end
  end

  // Instruction counter: advances on the cycle after each write, cleared on reload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      words_loaded <= '0;
    end else if (reload_hit) begin
      words_loaded <= '0;
    end else if (state == S_WRITE) begin
      words_loaded <= words_loaded + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed sequence of image loads with random payloads and
// random rx_valid gaps, checked against a stream/write-list model.
module tb_boot_loader;

  localparam int          ADDR_W = 12;
  localparam logic [11:0] BASE   = 12'h800;

  typedef logic [31:0] word_q_t[$];

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [7:0]        rx_data = 8'd0;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              reload = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              error;
  logic [ADDR_W-1:0] words_loaded;

  boot_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .MAX_WORDS(2048)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .reload(reload), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_rst(cpu_rst),
    .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  stream[$];
  logic [11:0] exp_addr[$];
  logic [63:0] exp_data[$];
  logic [11:0] cap_addr[$];
  logic [63:0] cap_data[$];
  logic [11:0] gold_addr[$];
  logic [63:0] gold_data[$];

  int   dbl_we = 0;
  int   we_rdy = 0;
  logic prev_we = 1'b0;

  // Capture every RAM write and note strobe-shape violations.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      cap_addr.push_back(mem_addr);
      cap_data.push_back(mem_wdata);
      if (prev_we) dbl_we <= dbl_we + 1;
      if (rx_ready !== 1'b0) we_rdy <= we_rdy + 1;
    end
    prev_we <= (mem_we === 1'b1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: stream = LEN_LO, LEN_HI, 4 LE bytes per word, XOR checksum.
  task automatic build_image(input word_q_t ins, input bit flip);
    logic [15:0] n;
    logic [7:0]  cs;
    stream.delete(); exp_addr.delete(); exp_data.delete();
    n = 16'(ins.size());
    stream.push_back(n[7:0]);
    stream.push_back(n[15:8]);
    for (int i = 0; i < ins.size(); i++) begin
      for (int b = 0; b < 4; b++) stream.push_back(8'((ins[i] >> (8 * b)) & 32'hff));
      exp_addr.push_back(BASE + 12'(i));
      exp_data.push_back({32'b0, ins[i]});
    end
    cs = 8'd0;
    foreach (stream[i]) cs = cs ^ stream[i];
    if (flip) cs = cs ^ 8'h01;
    stream.push_back(cs);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap + 1) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (rx_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      check("rx_ready_timeout", 64'(rx_ready), 64'd1);
      rx_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 rx_valid = 1'b0;
    end
  endtask

  task automatic send_range(input int first, input int last, input int gap_max);
    for (int i = first; i <= last; i++) send_byte(stream[i], $urandom_range(0, gap_max));
  endtask

  task automatic check_writes(input string tag);
    int m;
    check({tag, "_nwrites"}, 64'(cap_addr.size()), 64'(exp_addr.size()));
    m = (cap_addr.size() < exp_addr.size()) ? cap_addr.size() : exp_addr.size();
    for (int i = 0; i < m; i++) begin
      check({tag, "_addr"}, 64'(cap_addr[i]), 64'(exp_addr[i]));
      check({tag, "_data"}, cap_data[i], exp_data[i]);
    end
  endtask

  // Flags must still be idle the cycle after the final byte and settle one cycle later.
  task automatic expect_result(input string tag, input logic exp_done, input logic exp_err);
    @(negedge clk);
    check({tag, "_done_early"}, 64'(done), 64'd0);
    check({tag, "_err_early"}, 64'(error), 64'd0);
    check({tag, "_ready_term"}, 64'(rx_ready), 64'd0);
    @(negedge clk);
    check({tag, "_done"}, 64'(done), 64'(exp_done));
    check({tag, "_error"}, 64'(error), 64'(exp_err));
    check({tag, "_cpu_rst"}, 64'(cpu_rst), 64'(!exp_done));
  endtask

  task automatic do_reload(input string tag);
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1 reload = 1'b0;
    check({tag, "_rl_done"}, 64'(done), 64'd0);
    check({tag, "_rl_error"}, 64'(error), 64'd0);
    check({tag, "_rl_cpu_rst"}, 64'(cpu_rst), 64'd1);
    check({tag, "_rl_words"}, 64'(words_loaded), 64'd0);
    check({tag, "_rl_ready"}, 64'(rx_ready), 64'd1);
    cap_addr.delete();
    cap_data.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 64'(rx_ready), 64'd0);
    check({tag, "_cpu_rst"}, 64'(cpu_rst), 64'd1);
    check({tag, "_we"}, 64'(mem_we), 64'd0);
    check({tag, "_addr"}, 64'(mem_addr), 64'(BASE));
    check({tag, "_wdata"}, mem_wdata, 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_words"}, 64'(words_loaded), 64'd0);
  endtask

  initial begin
    word_q_t fib;
    word_q_t ins;

    // Power-on reset.
    #2 rst = 1'b1;
    #1 check_reset_vals("por");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 check("por_ready_after", 64'(rx_ready), 64'd1);

    // 8-word image, correct checksum.
    fib = '{32'h91000000, 32'h91000421, 32'h8b010002, 32'h8b020023,
            32'h8b030044, 32'h8b040065, 32'hd65f03c0, 32'h14000000};
    build_image(fib, 1'b0);
    cap_addr.delete(); cap_data.delete();
    send_range(0, stream.size() - 1, 0);
    expect_result("fib", 1'b1, 1'b0);
    check_writes("fib");
    check("fib_words", 64'(words_loaded), 64'd8);

    // Same image, checksum bit flipped.
    do_reload("fib");
    build_image(fib, 1'b1);
    send_range(0, stream.size() - 1, 0);
    expect_result("badcs", 1'b0, 1'b1);
    check_writes("badcs");

    // Empty image.
    do_reload("badcs");
    ins = {};
    build_image(ins, 1'b0);
    send_range(0, stream.size() - 1, 1);
    expect_result("empty", 1'b1, 1'b0);
    check("empty_nwrites", 64'(cap_addr.size()), 64'd0);

    // Oversized length: 2049 words.
    do_reload("empty");
    send_byte(8'h01, 0);
    send_byte(8'h08, 0);
    @(negedge clk);
    check("big_ready", 64'(rx_ready), 64'd0);
    check("big_err_early", 64'(error), 64'd0);
    @(negedge clk);
    check("big_error", 64'(error), 64'd1);
    check("big_cpu_rst", 64'(cpu_rst), 64'd1);
    check("big_done", 64'(done), 64'd0);
    check("big_nwrites", 64'(cap_addr.size()), 64'd0);

    // Random 3-word image, gap-free then with random rx_valid gaps.
    do_reload("big");
    ins = {};
    for (int i = 0; i < 3; i++) ins.push_back($urandom);
    build_image(ins, 1'b0);
    send_range(0, stream.size() - 1, 0);
    expect_result("r3", 1'b1, 1'b0);
    check_writes("r3");
    gold_addr = cap_addr;
    gold_data = cap_data;
    do_reload("r3");
    build_image(ins, 1'b0);
    send_range(0, stream.size() - 1, 4);
    expect_result("r3gap", 1'b1, 1'b0);
    check_writes("r3gap");
    check("gap_vs_nogap_n", 64'(cap_addr.size()), 64'(gold_addr.size()));
    for (int i = 0; i < gold_addr.size() && i < cap_addr.size(); i++) begin
      check("gap_vs_nogap_addr", 64'(cap_addr[i]), 64'(gold_addr[i]));
      check("gap_vs_nogap_data", cap_data[i], gold_data[i]);
    end

    // Reset in the middle of word 1 of a 2-word image.
    do_reload("r3gap");
    ins = {};
    for (int i = 0; i < 2; i++) ins.push_back($urandom);
    build_image(ins, 1'b0);
    send_range(0, 7, 2);
    @(negedge clk);
    rst = 1'b1;
    #1 check_reset_vals("midrst");
    check("midrst_word0_written", 64'(cap_addr.size()), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_no_partial_write", 64'(cap_addr.size()), 64'd1);
    check("midrst_words", 64'(words_loaded), 64'd0);

    // Fresh 1-word image after the abort, then reload.
    cap_addr.delete(); cap_data.delete();
    ins = {};
    ins.push_back($urandom);
    build_image(ins, 1'b0);
    send_range(0, stream.size() - 1, 1);
    expect_result("one", 1'b1, 1'b0);
    check_writes("one");
    do_reload("one");

    check("we_never_back_to_back", 64'(dbl_we), 64'd0);
    check("we_with_ready_low", 64'(we_rdy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
# boot_loader

Byte-stream program loader that writes a CPU image into unified RAM starting at `BASE_ADDR` and holds the CPU in reset until the image is complete and its checksum has passed. It sits between a serial byte source (UART receiver or test host) and the RAM write port shared with `datapath_core`. It is the writer for the instruction fetch path: it deposits each 32-bit instruction as `{32'b0, instr}` at consecutive 64-bit word addresses.

## Interface
- `BASE_ADDR`, default 12'h800: word address of the first instruction.
- `ADDR_W`, default 12: RAM word-address width.
- `MAX_WORDS`, default 2048: largest accepted instruction count; `BASE_ADDR + MAX_WORDS` must be ≤ 2^`ADDR_W`.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `rx_data`, in, 8: incoming byte.
- `rx_valid`, in, 1: `rx_data` is valid.
- `rx_ready`, out, 1: loader accepts the byte this cycle. A byte transfers when `rx_valid && rx_ready`.
- `reload`, in, 1: one-cycle pulse that restarts loading from DONE or ERROR.
- `mem_we`, out, 1: RAM write strobe, one cycle per instruction.
- `mem_addr`, out, `ADDR_W`: RAM word address.
- `mem_wdata`, out, 64: `{32'b0, instr}`.
- `cpu_rst`, out, 1: held high while the CPU must stay in reset.
- `done`, out, 1: image loaded and checksum good.
- `error`, out, 1: length or checksum failure.
- `words_loaded`, out, `ADDR_W`: number of instructions written so far.

## Operation
- Stream format, in order:
  - LEN_LO, LEN_HI: 16-bit instruction count N, little-endian.
  - N × 4 instruction bytes, each instruction little-endian (byte 0 = instr[7:0]).
  - One checksum byte equal to the XOR of every preceding byte, including the length bytes.
- States: S_LEN_LO, S_LEN_HI, S_INSTR, S_WRITE, S_CSUM, S_DONE, S_ERROR. Reset state is S_LEN_LO.
- `rx_ready` = 1 in S_LEN_LO, S_LEN_HI, S_INSTR and S_CSUM. It is 0 in S_WRITE, S_DONE and S_ERROR, and 0 while `rst` is high.
- S_LEN_LO: on a transfer, latch the low byte and go to S_LEN_HI.
- S_LEN_HI: on a transfer, form N.
  - N > MAX_WORDS → S_ERROR.
  - N = 0 → S_CSUM.
  - Otherwise → S_INSTR with byte index 0.
- S_INSTR: on each transfer, shift the byte into the 32-bit assembly register and increment the 2-bit byte index. When the 4th byte transfers → S_WRITE.
- S_WRITE: one cycle.
  - `mem_we`=1, `mem_addr`=`BASE_ADDR`+`words_loaded`, `mem_wdata`={32'b0, assembled instr}.
  - Next cycle `words_loaded` increments.
  - Go to S_CSUM if the new count equals N, else to S_INSTR.
- Running XOR is updated on every transferred byte except the checksum byte.
- S_CSUM: on a transfer, compare the byte with the running XOR.
  - Equal → S_DONE.
  - Not equal → S_ERROR.
- S_DONE: `done`=1, `cpu_rst`=0. `reload` → S_LEN_LO.
- S_ERROR: `error`=1, `cpu_rst`=1. `reload` → S_LEN_LO.
- On `reload`: next cycle `done`=0, `error`=0, `cpu_rst`=1, `words_loaded`=0, XOR cleared. RAM contents are not cleared.
- `reload` has no effect in any other state.
- No address wrap is possible, because N is bounded by MAX_WORDS.

## Timing
- Reset values, asserted immediately and asynchronously:
  - state=S_LEN_LO
  - `cpu_rst`=1, `mem_we`=0, `mem_addr`=`BASE_ADDR`, `mem_wdata`=0
  - `done`=0, `error`=0, `words_loaded`=0
  - `rx_ready`=0 while `rst` is high; 1 in the first cycle after deassertion.
- Last byte of an instruction transfers at edge t:
  - `mem_we`=1 during cycle t..t+1, with `rx_ready`=0.
  - `rx_ready`=1 again from edge t+1.
  - Minimum throughput is 5 cycles per instruction.
- Checksum byte transfers at edge t: `done`/`cpu_rst` (or `error`) change at edge t+1.
- `rx_valid` gaps of any length are legal. State and partial instruction are held across gaps.
- Reset mid-load aborts immediately; the partial instruction is discarded and no write is issued.
- `mem_we` is never high for more than one consecutive cycle.

## Test plan
- 8-word Fibonacci image (e.g. instr0=32'h91000000) with a correct checksum:
  - 8 writes at 0x800–0x807 with the correct `mem_wdata`.
  - `done`=1 and `cpu_rst`=0 one cycle after the checksum byte.
- Same image with a flipped checksum bit:
  - all 8 writes occur, then `error`=1, `cpu_rst` stays 1, `done`=0.
- N=0, checksum 8'h00:
  - no `mem_we`, `done`=1.
- N=2049 (bytes 8'h01, 8'h08):
  - `error`=1 one cycle after LEN_HI, `rx_ready`=0, no writes.
- Random `rx_valid` gaps within a 3-word image:
  - identical writes and addresses to the gap-free run.
- `rst` pulse after 2 bytes of word 1, then `reload` after DONE:
  - outputs return to their reset values; a fresh 1-word image writes 0x800; after `reload`, `cpu_rst`=1 and `done`=0.
